// File: rtl/inst_fetch_unit_pkg.sv
// Shared widths, reset PC and the fetch-entry layout for the instruction fetch stage.
package inst_fetch_unit_pkg;

   localparam int IFU_ADDR_W   = 10;
   localparam int IFU_DATA_W   = 16;
   localparam int IFU_RESET_PC = 0;

   typedef struct packed {
      logic [IFU_ADDR_W-1:0] pc;
      logic [IFU_DATA_W-1:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry FIFO between the memory return path and decode; flush empties it in one edge.
module fetch_skid_buffer
   import inst_fetch_unit_pkg::*;
#(
   parameter int W = $bits(fetch_entry_t)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         enq,
   input  logic [W-1:0] enq_data,
   input  logic         deq,
   input  logic         flush,
   output logic [1:0]   count,
   output logic [W-1:0] head
);

   logic [W-1:0] slot [2];
   logic         rd_ptr;
   logic         wr_ptr;

   assign head = slot[rd_ptr];

   // Slots are not cleared on flush; count alone decides validity.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slot[0] <= '0;
         slot[1] <= '0;
         rd_ptr  <= 1'b0;
         wr_ptr  <= 1'b0;
         count   <= 2'd0;
      end else if (flush) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (enq) begin
            slot[wr_ptr] <= enq_data;
            wr_ptr       <= ~wr_ptr;
         end
         if (deq) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + {1'b0, enq} - {1'b0, deq};
      end
   end

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: issues one address per cycle to a 1-cycle memory and queues returns for decode.
module inst_fetch_unit
   import inst_fetch_unit_pkg::*;
#(
   parameter int ADDR_W   = IFU_ADDR_W,
   parameter int DATA_W   = IFU_DATA_W,
   parameter int RESET_PC = IFU_RESET_PC
) (
   input  logic              clk,
   input  logic              reset,
   output logic [ADDR_W-1:0] addr_inst,
   input  logic [DATA_W-1:0] out_inst,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              halt,
   output logic [DATA_W-1:0] inst,
   output logic [ADDR_W-1:0] inst_pc,
   output logic              inst_valid,
   input  logic              inst_ready
);

   logic [ADDR_W-1:0]        pc;
   logic [ADDR_W-1:0]        pc_q;
   logic                     inflight;
   logic [1:0]               count;
   logic [ADDR_W+DATA_W-1:0] head;
   logic                     pop;
   logic [1:0]               occupancy;
   logic                     issue;

   assign addr_inst  = pc;
   assign inst_valid = (count != 2'd0);
   assign {inst_pc, inst} = head;
   assign pop        = inst_valid && inst_ready;

   // Entries that will be held after this edge; issuing only below 2 keeps the buffer from overflowing.
   assign occupancy = count - {1'b0, pop} + {1'b0, inflight};
   assign issue     = !redirect && !halt && (occupancy < 2'd2);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc       <= ADDR_W'(RESET_PC);
         pc_q     <= '0;
         inflight <= 1'b0;
      end else if (redirect) begin
         pc       <= redirect_pc;
         inflight <= 1'b0;
      end else if (issue) begin
         pc       <= pc + 1'b1;
         pc_q     <= pc;
         inflight <= 1'b1;
      end else begin
         inflight <= 1'b0;
      end
   end

   fetch_skid_buffer #(
      .W (ADDR_W + DATA_W)
   ) u_buf (
      .clk      (clk),
      .reset    (reset),
      .enq      (inflight && !redirect),
      .enq_data ({pc_q, out_inst}),
      .deq      (pop),
      .flush    (redirect),
      .count    (count),
      .head     (head)
   );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed plus randomized checks of inst_fetch_unit against an in-order delivery model.
module tb_inst_fetch_unit;

   localparam int AW = 10;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] addr_inst;
   logic [DW-1:0] out_inst;
   logic          redirect;
   logic [AW-1:0] redirect_pc;
   logic          halt;
   logic [DW-1:0] inst;
   logic [AW-1:0] inst_pc;
   logic          inst_valid;
   logic          inst_ready;

   int            n_checks = 0;
   int            n_fail   = 0;
   int            delivered = 0;
   logic [AW-1:0] exp_pc;

   inst_fetch_unit dut (
      .clk         (clk),
      .reset       (reset),
      .addr_inst   (addr_inst),
      .out_inst    (out_inst),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .halt        (halt),
      .inst        (inst),
      .inst_pc     (inst_pc),
      .inst_valid  (inst_valid),
      .inst_ready  (inst_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      return 16'hA000 + DW'(a);
   endfunction

   // Memory with mem[i] = 0xA000 + i, one-cycle read latency.
   always @(posedge clk) out_inst <= mem_word(addr_inst);

   function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endfunction

   // Called at a falling edge with inputs already set: score any transfer, then advance one clock.
   task automatic cycle();
      #1;
      if (inst_valid === 1'b1 && inst_ready) begin
         chk("pop_pc", 32'(inst_pc), 32'(exp_pc));
         chk("pop_inst", 32'(inst), 32'(mem_word(exp_pc)));
         exp_pc = exp_pc + 1'b1;
         delivered++;
      end
      if (redirect) exp_pc = redirect_pc;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic [AW-1:0] a0;
      logic [AW-1:0] wp;
      int            d0;
      int            waited;

      reset = 1'b1; redirect = 1'b0; redirect_pc = '0; halt = 1'b0; inst_ready = 1'b1;
      exp_pc = '0;
      @(negedge clk);
      chk("rst_valid", 32'(inst_valid), 32'd0);
      chk("rst_inst", 32'(inst), 32'd0);
      chk("rst_inst_pc", 32'(inst_pc), 32'd0);
      chk("rst_addr", 32'(addr_inst), 32'd0);
      reset = 1'b0;

      // Startup latency and streaming
      cycle();
      chk("first_edge_valid", 32'(inst_valid), 32'd0);
      chk("first_edge_addr", 32'(addr_inst), 32'd1);
      cycle();
      chk("second_edge_valid", 32'(inst_valid), 32'd1);
      chk("second_edge_pc", 32'(inst_pc), 32'd0);
      repeat (3) begin
         cycle();
         chk("stream_valid", 32'(inst_valid), 32'd1);
      end
      chk("stall_head", 32'(inst_pc), 32'd3);

      // Stall with head pc 3
      inst_ready = 1'b0;
      repeat (5) cycle();
      chk("stall_valid", 32'(inst_valid), 32'd1);
      chk("stall_hold_pc", 32'(inst_pc), 32'd3);
      chk("stall_hold_inst", 32'(inst), 32'hA003);
      chk("stall_addr", 32'(addr_inst), 32'd5);
      inst_ready = 1'b1;
      repeat (4) begin
         chk("release_valid", 32'(inst_valid), 32'd1);
         cycle();
      end

      // Fill with 7,8 then redirect
      chk("prefill_head", 32'(inst_pc), 32'd7);
      inst_ready = 1'b0;
      cycle();
      chk("full_addr", 32'(addr_inst), 32'd9);
      redirect = 1'b1; redirect_pc = 10'h200;
      cycle();
      redirect = 1'b0;
      chk("redir_flush_valid", 32'(inst_valid), 32'd0);
      inst_ready = 1'b1;
      cycle();
      chk("redir_e1_valid", 32'(inst_valid), 32'd0);
      cycle();
      chk("redir_e2_valid", 32'(inst_valid), 32'd1);
      chk("redir_pc", 32'(inst_pc), 32'h200);
      chk("redir_inst", 32'(inst), 32'hA200);
      repeat (3) cycle();

      // Redirect near the top of the address space, pop in the same cycle
      redirect = 1'b1; redirect_pc = 10'h3FE;
      cycle();
      redirect = 1'b0;
      repeat (2) cycle();
      wp = 10'h3FE;
      repeat (4) begin
         chk("wrap_valid", 32'(inst_valid), 32'd1);
         chk("wrap_pc", 32'(inst_pc), 32'(wp));
         wp = wp + 1'b1;
         cycle();
      end

      // Halt in steady state
      halt = 1'b1;
      a0 = addr_inst;
      d0 = delivered;
      repeat (6) begin
         cycle();
         chk("halt_addr", 32'(addr_inst), 32'(a0));
      end
      chk("halt_drain_valid", 32'(inst_valid), 32'd0);
      chk("halt_at_most_2", 32'(delivered - d0 <= 2), 32'd1);
      halt = 1'b0;
      repeat (2) cycle();
      chk("halt_resume_pc", 32'(inst_pc), 32'(a0));
      repeat (3) cycle();

      // Randomized traffic
      repeat (400) begin
         inst_ready  = 1'($urandom_range(0, 3) != 0);
         halt        = ($urandom_range(0, 9) == 0);
         redirect    = ($urandom_range(0, 19) == 0);
         redirect_pc = AW'($urandom);
         cycle();
      end
      redirect = 1'b0; halt = 1'b0; inst_ready = 1'b1;
      waited = 0;
      while (inst_valid !== 1'b1 && waited < 4) begin
         cycle();
         waited++;
      end
      chk("random_recover_valid", 32'(inst_valid), 32'd1);
      repeat (4) cycle();

      // Asynchronous reset mid-cycle while streaming
      #2 reset = 1'b1;
      #1;
      chk("async_rst_valid", 32'(inst_valid), 32'd0);
      chk("async_rst_addr", 32'(addr_inst), 32'd0);
      exp_pc = '0;
      @(negedge clk);
      reset = 1'b0;
      cycle();
      chk("restart_e1_valid", 32'(inst_valid), 32'd0);
      cycle();
      chk("restart_e2_valid", 32'(inst_valid), 32'd1);
      chk("restart_pc", 32'(inst_pc), 32'd0);
      repeat (5) cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
